// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution sliding-window buffer.
package conv_pkg;

  localparam int PIXEL_W = 16;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    PAD  = 2'd2
  } state_t;

  // Columns that must be present before the first window of a row is complete.
  function automatic int win_threshold(input int k, input bit pad_en);
    return pad_en ? (k + 1) / 2 : k;
  endfunction

endpackage

// File: rtl/conv_window_row.sv
// One row of the K x K window: a K-deep shift line, oldest pixel at index 0.
module conv_window_row
  import conv_pkg::*;
#(
  parameter int W = 16,
  parameter int K = 3
) (
  input  logic           clk,
  input  logic           arst_n_in,
  input  logic           shift,
  input  logic           clr,
  input  logic [W-1:0]   din,
  output logic [K*W-1:0] line
);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      line <= '0;
    end else if (shift) begin
      // A clear alongside a shift keeps only the incoming pixel.
      for (int c = 0; c < K - 1; c++) begin
        line[c*W +: W] <= clr ? '0 : line[(c+1)*W +: W];
      end
      line[(K-1)*W +: W] <= din;
    end else if (clr) begin
      line <= '0;
    end
  end

endmodule

// File: rtl/conv_window_shifter.sv
// K x K sliding-window buffer with valid/ready flow control and row tracking.
// Optional left/right zero padding is enabled with CONV_WINDOW_ZERO_PAD_EN.
module conv_window_shifter
  import conv_pkg::*;
#(
  parameter int IO_DATA_WIDTH     = 16,
  parameter int KERNEL_SIZE       = 3,
  parameter int FEATURE_MAP_WIDTH = 1024
) (
  input  logic                                       clk,
  input  logic                                       arst_n_in,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [KERNEL_SIZE*IO_DATA_WIDTH-1:0]       in_col,
  input  logic                                       row_start,
  input  logic                                       row_end,
  output logic                                       win_valid,
  input  logic                                       win_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*IO_DATA_WIDTH-1:0] window,
  output logic                                       win_last
);

  localparam int K  = KERNEL_SIZE;
  localparam int W  = IO_DATA_WIDTH;
  localparam int CW = $clog2(FEATURE_MAP_WIDTH + 1);
`ifdef CONV_WINDOW_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  localparam int T = win_threshold(K, PAD_EN);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
  logic            win_valid_nxt, win_last_nxt;
  logic            hold, accept, shift, clr, pad_shift;
  logic [K*W-1:0]  shift_col;

  assign hold     = win_valid && !win_ready;
  // Held low during reset so the upstream never sees a spurious ready.
  assign in_ready = arst_n_in && (state != PAD) && !hold;
  assign accept   = in_valid && in_ready;

`ifdef CONV_WINDOW_ZERO_PAD_EN
  localparam int P  = (K - 1) / 2;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  logic [PW-1:0] pad_cnt;
  logic          pad_last;

  assign pad_shift = (state == PAD) && !hold;
  assign pad_last  = (int'(pad_cnt) == P - 1);
  assign clr       = accept && row_start;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)     pad_cnt <= '0;
    else if (accept)    pad_cnt <= '0;
    else if (pad_shift) pad_cnt <= pad_cnt + PW'(1);
  end
`else
  assign pad_shift = 1'b0;
  assign clr       = 1'b0;
`endif

  assign shift     = accept || pad_shift;
  assign shift_col = accept ? in_col : '0;
  assign cnt_inc   = (cnt >= CW'(K)) ? CW'(K) : cnt + CW'(1);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    win_valid_nxt = win_valid && !win_ready;
    win_last_nxt  = win_last;
    if (accept) begin
      cnt_nxt   = row_start ? CW'(1) : cnt_inc;
      state_nxt = (cnt_nxt >= CW'(T)) ? RUN : FILL;
      if (cnt_nxt >= CW'(T)) begin
        win_valid_nxt = 1'b1;
        win_last_nxt  = row_end;
      end
`ifdef CONV_WINDOW_ZERO_PAD_EN
      // The row's last window comes from the final padded column instead.
      if (row_end && P > 0) begin
        state_nxt    = PAD;
        win_last_nxt = 1'b0;
      end
`endif
    end
`ifdef CONV_WINDOW_ZERO_PAD_EN
    else if (pad_shift) begin
      win_valid_nxt = 1'b1;
      win_last_nxt  = pad_last;
      if (pad_last) begin
        state_nxt = FILL;
        cnt_nxt   = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state     <= FILL;
      cnt       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      win_valid <= win_valid_nxt;
      win_last  <= win_last_nxt;
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    conv_window_row #(
      .W (W),
      .K (K)
    ) u_row (
      .clk       (clk),
      .arst_n_in (arst_n_in),
      .shift     (shift),
      .clr       (clr),
      .din       (shift_col[r*W +: W]),
      .line      (window[r*K*W +: K*W])
    );
  end

endmodule
